uart_rx_frame_engine: RTL
=========================

UART_RX_FRAME_ENGINE -- requirements
Module: uart_rx_frame_engine

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: sample_tick pulses per bit period, even and >= 8.
REQ-002 SHALL have parameter MAX_DATA_BITS, default 9: widest supported character, range 5..9.
REQ-003 SHALL have port pclk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port preset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port rx_en, input, 1: receiver enable.
REQ-006 SHALL have port uart_rxd, input, 1: asynchronous serial line, idle high.
REQ-007 SHALL have port sample_tick, input, 1: one-pclk pulse at OVERSAMPLE x baud rate.
REQ-008 SHALL have port cfg_data_bits, input, 4: character length 5..MAX_DATA_BITS.
REQ-009 SHALL have ports cfg_parity_en, cfg_parity_odd and cfg_stop2, input, 1 each: parity enable, odd (1) or even (0) parity, two stop bits.
REQ-010 SHALL have port rx_data, output, MAX_DATA_BITS: received character, right-justified.
REQ-011 SHALL have port rx_valid, output, 1: holding register full.
REQ-012 SHALL have port rx_ready, input, 1: consumer accepts rx_data when rx_valid & rx_ready.
REQ-013 SHALL have ports parity_err and frame_err, output, 1 each: status qualified by rx_valid.
REQ-014 SHALL have ports overrun_err, output, 1 (one-cycle pulse), and uart_break, output, 1 (level).

Function
REQ-015 uart_rxd SHALL pass a 2-flop synchroniser, reset value 1; all decisions use the synchronised value.
REQ-016 Each bit SHALL be majority-voted from samples at tick counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, counting from 0 at bit start.
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2 and BREAK.
REQ-018 IDLE->START when rx_en & rxd_sync==0; tick counter cleared; cfg_* latched and held for the whole frame.
REQ-019 START: vote==1 at the mid-sample -> IDLE (false start, no flags); otherwise at tick OVERSAMPLE-1 -> DATA.
REQ-020 DATA: shift the voted bit LSB-first at the end of each bit; after the latched bit count -> PARITY if parity is enabled, else STOP1.
REQ-021 cfg_data_bits below 5 SHALL be treated as 5; values above MAX_DATA_BITS SHALL be treated as MAX_DATA_BITS; rx_data bits above the length SHALL be 0.
REQ-022 PARITY: parity_err = XOR(data, parity bit) != cfg_parity_odd; cleared when parity is disabled.
REQ-023 STOP1 mid-sample:
  - vote==0 with all data and parity bits 0 -> BREAK.
  - otherwise frame_err = ~vote.
  - if cfg_stop2 -> STOP2, else complete.
REQ-024 STOP2 mid-sample: frame_err |= ~vote, then complete.
REQ-025 Completion SHALL occur at the stop-bit mid-sample and return to IDLE the next cycle, for resynchronisation.
REQ-026 On completion with rx_valid==0: load rx_data, parity_err and frame_err; assert rx_valid the next cycle.
REQ-027 On completion with rx_valid==1 and no handshake that cycle: drop the new character, pulse overrun_err for 1 cycle, and leave the held data unchanged.
REQ-028 On completion coinciding with rx_valid & rx_ready: load the new character; rx_valid stays 1; no overrun.
REQ-029 rx_valid SHALL clear the cycle after rx_valid & rx_ready.
REQ-030 BREAK: uart_break=1 while in BREAK; BREAK->IDLE the cycle after rxd_sync==1; no rx_valid for a break frame.
REQ-031 rx_en deasserted in any non-IDLE state SHALL force IDLE next cycle, discarding the partial frame; the holding register is unaffected.
REQ-032 Latency SHALL be: rx_valid rises exactly 2 (synchroniser) + 1 pclk after the final stop-bit mid-sample tick.

Reset
REQ-033 preset SHALL set: state IDLE, counters 0, shift register 0, synchroniser 1, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, overrun_err 0, uart_break 0.
REQ-034 preset SHALL take priority over every other input, including mid-frame.

Structure
REQ-035 Package uart_rx_pkg SHALL hold the state enumeration and the OVERSAMPLE and MAX_DATA_BITS defaults.
REQ-036 Sub-module uart_rx_sampler SHALL contain the synchroniser, tick counter and 3-sample majority vote, outputting vote, mid_edge and bit_end.

Verification
REQ-037 8N1, OVERSAMPLE=16, byte 0xA5, rx_ready=1 -> rx_valid for 1 cycle with rx_data=0x0A5 and no errors.
REQ-038 7E2, character 0x41, parity bit 1 -> parity_err=1, frame_err=0; with parity bit 0 -> both errors 0.
REQ-039 8N1 with stop bit 0 and data 0x55 -> frame_err=1; with data 0x00 -> BREAK, uart_break=1 until line high, then IDLE, no rx_valid.
REQ-040 Two frames 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x011, overrun_err pulses once.
REQ-041 Low glitch of 4 ticks on an idle line -> START->IDLE, no flags; a single-tick low spike at the mid-sample of a data bit is out-voted.
REQ-042 rx_en dropped during bit 3, then restored with a fresh 0x3C frame -> only 0x03C delivered; preset asserted mid-frame -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame engine.
//   - rx_state_e    : receiver FSM state encoding (also exported on state_dbg)
//   - *_DEF         : default oversampling ratio and widest character
//   - clamp_len()   : folds an out-of-range character length into 5..max
package uart_rx_pkg;

  localparam int OVERSAMPLE_DEF    = 16;
  localparam int MAX_DATA_BITS_DEF = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_BREAK  = 3'd6
  } rx_state_e;

  function automatic logic [3:0] clamp_len(input logic [3:0] req, input int max_bits);
    if (int'(req) < 5)             return 4'd5;
    else if (int'(req) > max_bits) return 4'(max_bits);
    else                           return req;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning and bit timing for the UART receiver.
//   pclk, preset : clock, synchronous active-high reset
//   uart_rxd     : raw asynchronous serial line
//   sample_tick  : one-pclk pulse at OVERSAMPLE x baud
//   clr          : hold the tick counter at 0 (asserted while the FSM idles)
//   rxd_sync     : line after the 2-flop synchroniser
//   vote         : 3-sample majority; fresh during mid_edge, held afterwards
//   mid_edge     : pulse on the third (last) vote sample of a bit
//   bit_end      : pulse on the last tick of a bit period
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic uart_rxd,
  input  logic sample_tick,
  input  logic clr,
  output logic rxd_sync,
  output logic vote,
  output logic mid_edge,
  output logic bit_end
);

  localparam int CW = $clog2(OVERSAMPLE);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q;
  logic          s0_q, s1_q, vote_q;
  logic          maj;

  assign rxd_sync = sync2_q;
  // Third sample is the live synchronised value on the mid_edge tick.
  assign maj      = (s0_q & s1_q) | (s0_q & rxd_sync) | (s1_q & rxd_sync);
  assign mid_edge = sample_tick && (cnt_q == CW'(OVERSAMPLE/2 + 1));
  assign bit_end  = sample_tick && (cnt_q == CW'(OVERSAMPLE - 1));
  assign vote     = mid_edge ? maj : vote_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      vote_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      if (clr) begin
        cnt_q <= '0;
      end else if (sample_tick) begin
        cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
        if (cnt_q == CW'(OVERSAMPLE/2 - 1)) s0_q <= rxd_sync;
        if (cnt_q == CW'(OVERSAMPLE/2))     s1_q <= rxd_sync;
        if (mid_edge)                       vote_q <= maj;
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame_engine.sv
// UART receive frame engine: start detection, 5..9 data bits LSB first,
// optional parity, one or two stop bits, break detection and a one-deep
// holding register.
//   pclk, preset            : clock, synchronous active-high reset
//   rx_en                   : receiver enable (drop aborts the current frame)
//   uart_rxd, sample_tick   : serial line and OVERSAMPLE x baud tick
//   cfg_*                   : frame format, latched at start-bit detection
//   rx_data, rx_valid       : holding register and its full flag
//   rx_ready                : consumer accept
//   parity_err, frame_err   : status of the held character
//   overrun_err             : one-cycle pulse when a character is dropped
//   uart_break              : high while the line is held in break
//   state_dbg               : current FSM state
// Handshake: a character transfers on every pclk edge where
// rx_valid & rx_ready; rx_valid never drops without that transfer (except
// reset), and rx_data/status stay stable while rx_valid is high unless a new
// character is loaded on the same edge as a transfer.
module uart_rx_frame_engine
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE    = OVERSAMPLE_DEF,
  parameter int MAX_DATA_BITS = MAX_DATA_BITS_DEF
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     rx_en,
  input  logic                     uart_rxd,
  input  logic                     sample_tick,
  input  logic [3:0]               cfg_data_bits,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_odd,
  input  logic                     cfg_stop2,
  output logic [MAX_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun_err,
  output logic                     uart_break,
  output logic [2:0]               state_dbg
);

  rx_state_e state, state_d;

  logic rxd_sync, vote, mid_edge, bit_end;

  logic [3:0]               bit_cnt, len_q;
  logic                     par_en_q, par_odd_q, stop2_q;
  logic                     par_bit_q, par_err_q, frame_err_q;
  logic [MAX_DATA_BITS-1:0] shift_q;

  logic frame_start, shift_en, par_cap, stop1_mid, complete;
  logic fe_new, is_break, hs;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .pclk        (pclk),
    .preset      (preset),
    .uart_rxd    (uart_rxd),
    .sample_tick (sample_tick),
    .clr         (state == ST_IDLE),
    .rxd_sync    (rxd_sync),
    .vote        (vote),
    .mid_edge    (mid_edge),
    .bit_end     (bit_end)
  );

  assign uart_break = (state == ST_BREAK);
  assign state_dbg  = state;
  assign hs         = rx_valid & rx_ready;

  always_ff @(posedge pclk) begin
    if (preset) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    frame_start = 1'b0;
    shift_en    = 1'b0;
    par_cap     = 1'b0;
    stop1_mid   = 1'b0;
    complete    = 1'b0;
    fe_new      = ~vote;
    // A low stop bit after an all-zero character (and parity) is a break.
    is_break    = !vote && (shift_q == '0) && !(par_en_q && par_bit_q);
    if (state != ST_IDLE && !rx_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rx_en && !rxd_sync) begin
            state_d     = ST_START;
            frame_start = 1'b1;
          end
        end
        ST_START: begin
          if (mid_edge && vote) state_d = ST_IDLE;
          else if (bit_end)     state_d = ST_DATA;
        end
        ST_DATA: begin
          if (bit_end) begin
            shift_en = 1'b1;
            if (bit_cnt == len_q - 4'd1) state_d = par_en_q ? ST_PARITY : ST_STOP1;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            par_cap = 1'b1;
            state_d = ST_STOP1;
          end
        end
        ST_STOP1: begin
          if (mid_edge) begin
            stop1_mid = 1'b1;
            if (is_break)     state_d = ST_BREAK;
            else if (stop2_q) state_d = ST_STOP2;
            else begin
              complete = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
        ST_STOP2: begin
          // STOP2 is entered mid-bit; bit_cnt marks that the second bit began.
          if (mid_edge && bit_cnt != 4'd0) begin
            fe_new   = frame_err_q | ~vote;
            complete = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BREAK: begin
          if (rxd_sync) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Frame datapath: latched format, bit counter, shift register, parity.
  always_ff @(posedge pclk) begin
    if (preset) begin
      bit_cnt     <= '0;
      len_q       <= 4'd5;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (frame_start) begin
        len_q       <= clamp_len(cfg_data_bits, MAX_DATA_BITS);
        par_en_q    <= cfg_parity_en;
        par_odd_q   <= cfg_parity_odd;
        stop2_q     <= cfg_stop2;
        shift_q     <= '0;
        par_bit_q   <= 1'b0;
        par_err_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (state_d != state)                 bit_cnt <= '0;
      else if (shift_en)                    bit_cnt <= bit_cnt + 4'd1;
      else if (state == ST_STOP2 && bit_end) bit_cnt <= 4'd1;
      // Writing by index keeps the character right-justified.
      if (shift_en) shift_q[bit_cnt] <= vote;
      if (par_cap) begin
        par_bit_q <= vote;
        par_err_q <= ((^shift_q) ^ vote) != par_odd_q;
      end
      if (stop1_mid) frame_err_q <= ~vote;
    end
  end

  // Holding register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= complete && rx_valid && !hs;
      if (complete && (!rx_valid || hs)) begin
        rx_data    <= shift_q;
        parity_err <= par_err_q;
        frame_err  <= fe_new;
        rx_valid   <= 1'b1;
      end else if (hs) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
